// File: rtl/smem_ingress_arbiter.sv
// smem_ingress_arbiter
//   Round-robin arbiter that shares the single pe_mesh smem ingress FIFO among
//   N_REQ packet sources (host loader, DMA, debug injector, config ROM).
//   A requester that holds req_lock keeps the grant so its burst stays
//   contiguous. If a lock holder goes empty for too long, a watchdog releases
//   the lock and sets a sticky error flag.
//
// Ports
//   clk              clock
//   rst              asynchronous reset, active low
//   req_empty        per-requester FIFO empty flags
//   req_rdata        per-requester FIFO head packets
//   req_lock         per-requester "keep grant after this packet"
//   req_deq          per-requester dequeue strobe (one-hot or zero)
//   out_full         smem ingress FIFO full
//   out_enq          enqueue strobe to smem ingress FIFO
//   out_wdata        packet to smem ingress FIFO
//   grant_id         current or most recently granted requester
//   locked           arbiter is holding a locked burst
//   lock_timeout_err sticky flag, set when the watchdog forces a release
module smem_ingress_arbiter #(
  parameter int N_REQ        = 4,
  parameter int PKT_W        = 64,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_empty,
  input  logic [N_REQ-1:0][PKT_W-1:0]    req_rdata,
  input  logic [N_REQ-1:0]               req_lock,
  output logic [N_REQ-1:0]               req_deq,
  input  logic                           out_full,
  output logic                           out_enq,
  output logic [PKT_W-1:0]               out_wdata,
  output logic [$clog2(N_REQ)-1:0]       grant_id,
  output logic                           locked,
  output logic                           lock_timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gsel;
  logic [IW-1:0]   cand;
  logic [TW-1:0]   timer, timer_nxt;
  logic            stage_valid;
  logic [PKT_W-1:0] stage_data;
  logic            found;
  logic            stage_accept;
  logic            transfer;
  logic            err_set;

  // One-entry output stage; it refills in the same cycle it drains, which
  // keeps throughput at one packet per cycle.
  assign out_enq      = stage_valid & ~out_full;
  assign out_wdata    = stage_data;
  assign stage_accept = ~stage_valid | out_enq;
  assign locked       = (state == LOCKED);

  // Grant selection. The loop runs from the farthest candidate to the
  // nearest one, so the requester closest after rr_ptr wins.
  always_comb begin
    gsel  = grant_id;
    cand  = '0;
    found = 1'b0;
    if (state == LOCKED) begin
      found = ~req_empty[grant_id];
    end else begin
      for (int i = N_REQ; i >= 1; i--) begin
        cand = IW'((int'(rr_ptr) + i) % N_REQ);
        if (!req_empty[cand]) begin
          gsel  = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Gate on rst so no requester loses a packet while reset holds the stage.
  assign transfer = rst & found & stage_accept;

  always_comb begin
    req_deq = '0;
    if (transfer) req_deq[gsel] = 1'b1;
  end

  // Next-state logic and lock watchdog. The timer runs only while the holder
  // is empty. A holder that is non-empty but stalled by out_full is making
  // progress, so the timer does not count for it.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (transfer && req_lock[gsel]) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (transfer) begin
          timer_nxt = '0;
          if (!req_lock[gsel]) state_nxt = IDLE;
        end else if (req_empty[grant_id]) begin
          if (timer == TW'(LOCK_TIMEOUT - 1)) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            err_set   = 1'b1;
          end else begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and stage registers. Reset drops any packet held in the
  // stage and releases an active lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      timer            <= '0;
      rr_ptr           <= IW'(N_REQ - 1);
      grant_id         <= '0;
      stage_valid      <= 1'b0;
      stage_data       <= '0;
      lock_timeout_err <= 1'b0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      lock_timeout_err <= lock_timeout_err | err_set;
      if (transfer) begin
        rr_ptr      <= gsel;
        grant_id    <= gsel;
        stage_valid <= 1'b1;
        stage_data  <= req_rdata[gsel];
      end else if (out_enq) begin
        stage_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_smem_ingress_arbiter.sv
// tb_smem_ingress_arbiter
//   Directed bench for smem_ingress_arbiter (N_REQ=4, PKT_W=64,
//   LOCK_TIMEOUT=8). Requester FIFOs are modelled as queues. The bench samples
//   DUT outputs on the falling edge and updates the FIFO heads just after the
//   rising edge. Every packet the DUT enqueues is collected in obs.
module tb_smem_ingress_arbiter;

  localparam int N  = 4;
  localparam int PW = 64;
  localparam int LT = 8;

  typedef struct packed {
    logic          lk;
    logic [PW-1:0] d;
  } ent_t;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         req_empty;
  logic [N-1:0][PW-1:0] req_rdata;
  logic [N-1:0]         req_lock;
  logic [N-1:0]         req_deq;
  logic                 out_full;
  logic                 out_enq;
  logic [PW-1:0]        out_wdata;
  logic [1:0]           grant_id;
  logic                 locked;
  logic                 lock_timeout_err;

  ent_t          fq[N][$];
  logic [PW-1:0] obs[$];
  logic [N-1:0]  deq_s;
  logic          enq_s, locked_s, err_s;
  int            vectors, miscompares;

  smem_ingress_arbiter #(.N_REQ(N), .PKT_W(PW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .req_empty(req_empty), .req_rdata(req_rdata), .req_lock(req_lock),
    .req_deq(req_deq),
    .out_full(out_full), .out_enq(out_enq), .out_wdata(out_wdata),
    .grant_id(grant_id), .locked(locked), .lock_timeout_err(lock_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive each requester's empty, head and lock from its modelled FIFO.
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() == 0) begin
        req_empty[i] = 1'b1;
        req_rdata[i] = '0;
        req_lock[i]  = 1'b0;
      end else begin
        req_empty[i] = 1'b0;
        req_rdata[i] = fq[i][0].d;
        req_lock[i]  = fq[i][0].lk;
      end
    end
  endtask

  task automatic push(input int r, input logic [PW-1:0] d, input logic lk);
    ent_t e;
    e.lk = lk;
    e.d  = d;
    fq[r].push_back(e);
    refresh();
  endtask

  // Run one clock cycle. Sample outputs mid-cycle, then pop the FIFOs the
  // DUT dequeued at the rising edge.
  task automatic step();
    @(negedge clk);
    deq_s    = req_deq;
    enq_s    = out_enq;
    locked_s = locked;
    err_s    = lock_timeout_err;
    if (out_enq) obs.push_back(out_wdata);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (deq_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    vectors += 6;
    if (req_deq !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_deq: got %b, expected 0000", req_deq); end
    if (out_enq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_enq: got %b, expected 0", out_enq); end
    if (out_wdata !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h, expected 0", out_wdata); end
    if (grant_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_grant: got %0d, expected 0", grant_id); end
    if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %b, expected 0", locked); end
    if (lock_timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b, expected 0", lock_timeout_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [PW-1:0] got;
    logic [PW-1:0] exp_d;
    obs.delete();
    push(2, 64'hA1, 1'b0);
    push(2, 64'hA2, 1'b0);
    push(2, 64'hA3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      vectors += 2;
      if (deq_s !== ((c < 3) ? 4'b0100 : 4'b0000)) begin
        miscompares++; $display("[TB] FAIL single_deq[%0d]: got %b, expected %b", c, deq_s, (c < 3) ? 4'b0100 : 4'b0000);
      end
      if (enq_s !== (c >= 1 && c <= 3)) begin
        miscompares++; $display("[TB] FAIL single_enq[%0d]: got %b, expected %b", c, enq_s, (c >= 1 && c <= 3));
      end
    end
    for (int i = 0; i < 3; i++) begin
      got   = (i < obs.size()) ? obs[i] : 'x;
      exp_d = 64'hA1 + 64'(i);
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("[TB] FAIL single_data[%0d]: got %h, expected %h", i, got, exp_d); end
    end
    vectors++;
    if (grant_id !== 2'd2) begin miscompares++; $display("[TB] FAIL single_grant: got %0d, expected 2", grant_id); end
  endtask

  task automatic test_round_robin();
    int first, last, n;
    logic [PW-1:0] got;
    logic [PW-1:0] exp_d;
    do_reset();
    obs.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) push(r, 64'(32'h100 + r * 16 + k), 1'b0);
    first = -1; last = -1; n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (enq_s) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    vectors++;
    if (last - first + 1 != 8 || n != 8) begin
      miscompares++; $display("[TB] FAIL rr_no_gaps: got %0d enq over span %0d, expected 8 over 8", n, last - first + 1);
    end
    for (int i = 0; i < 8; i++) begin
      got   = (i < obs.size()) ? obs[i] : 'x;
      exp_d = 64'(32'h100 + (i % 4) * 16 + i / 4);
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("[TB] FAIL rr_order[%0d]: got %h, expected %h", i, got, exp_d); end
    end
  endtask

  task automatic test_locked_burst();
    logic [PW-1:0] got;
    logic [PW-1:0] exp_q[$];
    push(0, 64'h300, 1'b0);
    for (int c = 0; c < 3; c++) step();
    obs.delete();
    push(1, 64'h311, 1'b1);
    push(1, 64'h312, 1'b1);
    push(1, 64'h313, 1'b1);
    push(1, 64'h314, 1'b0);
    push(0, 64'h301, 1'b0);
    push(3, 64'h331, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step();
      if (c >= 1 && c <= 4) begin
        vectors++;
        if (locked_s !== (c <= 3)) begin
          miscompares++; $display("[TB] FAIL burst_locked[%0d]: got %b, expected %b", c, locked_s, (c <= 3));
        end
      end
    end
    exp_q = '{64'h311, 64'h312, 64'h313, 64'h314, 64'h331, 64'h301};
    for (int i = 0; i < 6; i++) begin
      got = (i < obs.size()) ? obs[i] : 'x;
      vectors++;
      if (got !== exp_q[i]) begin miscompares++; $display("[TB] FAIL burst_order[%0d]: got %h, expected %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int stall_deq, stall_enq;
    logic [PW-1:0] got;
    logic [PW-1:0] exp_d;
    obs.delete();
    for (int k = 0; k < 5; k++) push(0, 64'(32'h400 + k), 1'b0);
    step();
    step();
    out_full = 1'b1;
    stall_deq = 0; stall_enq = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (deq_s != 4'b0) stall_deq++;
      if (enq_s) stall_enq++;
    end
    out_full = 1'b0;
    vectors += 2;
    if (stall_deq > 1) begin miscompares++; $display("[TB] FAIL bp_stall_deq: got %0d, expected <= 1", stall_deq); end
    if (stall_enq != 0) begin miscompares++; $display("[TB] FAIL bp_stall_enq: got %0d, expected 0", stall_enq); end
    for (int c = 0; c < 8; c++) step();
    vectors++;
    if (obs.size() != 5) begin miscompares++; $display("[TB] FAIL bp_count: got %0d, expected 5", obs.size()); end
    for (int i = 0; i < 5; i++) begin
      got   = (i < obs.size()) ? obs[i] : 'x;
      exp_d = 64'(32'h400 + i);
      vectors++;
      if (got !== exp_d) begin miscompares++; $display("[TB] FAIL bp_data[%0d]: got %h, expected %h", i, got, exp_d); end
    end
  endtask

  task automatic test_timeout();
    push(2, 64'h520, 1'b1);
    push(0, 64'h501, 1'b0);
    step();
    vectors++;
    if (deq_s !== 4'b0100) begin miscompares++; $display("[TB] FAIL to_first_deq: got %b, expected 0100", deq_s); end
    for (int c = 1; c <= 8; c++) begin
      step();
      vectors += 2;
      if (locked_s !== 1'b1) begin miscompares++; $display("[TB] FAIL to_locked[%0d]: got %b, expected 1", c, locked_s); end
      if (deq_s !== 4'b0000) begin miscompares++; $display("[TB] FAIL to_deq[%0d]: got %b, expected 0000", c, deq_s); end
    end
    vectors++;
    if (err_s !== 1'b0) begin miscompares++; $display("[TB] FAIL to_err_early: got %b, expected 0", err_s); end
    step();
    vectors += 3;
    if (locked_s !== 1'b0) begin miscompares++; $display("[TB] FAIL to_released: got %b, expected 0", locked_s); end
    if (err_s !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err: got %b, expected 1", err_s); end
    if (deq_s !== 4'b0001) begin miscompares++; $display("[TB] FAIL to_next_grant: got %b, expected 0001", deq_s); end
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) push(1, 64'(32'h611 + k), 1'b1);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    vectors += 6;
    if (req_deq !== 4'b0) begin miscompares++; $display("[TB] FAIL ar_deq: got %b, expected 0000", req_deq); end
    if (out_enq !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_enq: got %b, expected 0", out_enq); end
    if (out_wdata !== 64'h0) begin miscompares++; $display("[TB] FAIL ar_wdata: got %h, expected 0", out_wdata); end
    if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_locked: got %b, expected 0", locked); end
    if (grant_id !== 2'd0) begin miscompares++; $display("[TB] FAIL ar_grant: got %0d, expected 0", grant_id); end
    if (lock_timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_err: got %b, expected 0", lock_timeout_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, 64'h601, 1'b0);
    step();
    vectors++;
    if (deq_s !== 4'b0001) begin miscompares++; $display("[TB] FAIL ar_restart_r0: got %b, expected 0001", deq_s); end
    step();
    vectors++;
    if (deq_s !== 4'b0010) begin miscompares++; $display("[TB] FAIL ar_then_r1: got %b, expected 0010", deq_s); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    out_full    = 1'b0;
    rst         = 1'b0;
    refresh();
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_locked_burst();
    test_backpressure();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/smem_ingress_arbiter.md
Name: smem_ingress_arbiter

Overview:
- Round-robin arbiter that shares one pe_mesh smem ingress port among N_REQ packet sources (host loader, DMA, debug injector, config ROM).
- Each requester presents a FIFO read side (empty/rdata, arbiter drives deq). The arbiter drives the write side (enqueue/wdata, observes full) of the smem ingress FIFO.
- Lock-based bursts keep configuration packet streams contiguous. A starvation watchdog releases a stalled lock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PKT_W, 64, packet_t width in bits.
- LOCK_TIMEOUT, 64, cycles a locked requester may stay empty before forced release (>=2).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- req_empty  input  [N_REQ]  requester FIFO empty.
- req_rdata  input  [N_REQ][PKT_W]  requester FIFO head packet.
- req_lock  input  [N_REQ]  hold grant after the current packet (high on every packet of a burst except the last).
- req_deq  output  [N_REQ]  dequeue strobe to requester FIFO.
- out_full  input  1  smem ingress FIFO full.
- out_enq  output  1  enqueue strobe to smem ingress FIFO.
- out_wdata  output  [PKT_W]  packet to smem ingress FIFO.
- grant_id  output  [$clog2(N_REQ)]  current or last granted requester.
- locked  output  1  FSM is in LOCKED.
- lock_timeout_err  output  1  sticky; set on forced release.

Behaviour:
- Reset (rst low, async) clears:
  - state=IDLE, stage_valid=0, rr_ptr=N_REQ-1, grant_id=0, timer=0, lock_timeout_err=0.
  - Outputs req_deq=0, out_enq=0, out_wdata=0.
- Output stage:
  - One-entry register {stage_valid, stage_data}.
  - out_enq = stage_valid & !out_full (combinational); out_wdata = stage_data.
  - Stage can accept when !stage_valid | out_enq.
- Transfer:
  - Occurs when the granted requester g has !req_empty[g] and the stage can accept.
  - req_deq[g]=1 for exactly that cycle; all other req_deq are 0.
  - stage_data <= req_rdata[g], stage_valid <= 1.
- Latency: req_deq to out_enq is 1 cycle if out_full=0. Sustained throughput is 1 packet/cycle.
- out_full held: stage fills, then req_deq stays 0. No packet is dropped or duplicated.
- IDLE:
  - Grant is computed combinationally: the first non-empty requester searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - If a transfer occurs: rr_ptr <= g, grant_id <= g.
  - If req_lock[g]=1 in the transfer cycle, go to LOCKED.
  - No non-empty requester: remain in IDLE, no deq.
- LOCKED:
  - Only grant_id may transfer; other requesters are ignored even if non-empty.
  - A transfer with req_lock[grant_id]=0 returns to IDLE; next arbitration starts at grant_id+1.
  - A transfer with req_lock=1 stays in LOCKED, timer <= 0.
  - Each cycle with req_empty[grant_id]=1: timer++.
  - When timer reaches LOCK_TIMEOUT-1: go to IDLE, set lock_timeout_err, timer <= 0.
  - timer does not count while out_full stalls a non-empty holder.
- Simultaneous requests: exactly one grant. Fairness: with all requesters continuously non-empty and unlocked, the grant order is 0,1,2,3,0,…
- rr_ptr wraps modulo N_REQ.
- lock_timeout_err clears only on reset.
- Reset mid-burst: the packet in the stage is discarded; the lock is released.

Test Plan:
- Single source: requester 2 has 3 packets 0xA1,0xA2,0xA3, lock=0, out_full=0.
  - req_deq[2] high for 3 consecutive cycles.
  - out_enq carries A1,A2,A3 on the following 3 cycles.
  - grant_id=2.
- Round-robin: all 4 requesters each hold 2 packets, no lock.
  - Output order is r0,r1,r2,r3,r0,r1,r2,r3 with no idle cycles.
- Locked burst: r1 sends 4 packets with lock=1,1,1,0 while r0 and r3 are non-empty.
  - The 4 r1 packets are contiguous on out_wdata; locked=1 throughout.
  - The next grant goes to r3, then r0.
- Backpressure: out_full=1 for 10 cycles mid-stream from r0 (5 packets).
  - At most 1 deq occurs during the stall; all 5 packets emerge in order, none duplicated.
- Timeout with LOCK_TIMEOUT=8: r2 sends 1 packet with lock=1, then goes empty.
  - After 8 empty cycles: locked=0 and lock_timeout_err=1.
  - r0's pending packet is then granted.
- Async reset: assert rst low mid-burst, between clock edges.
  - All outputs go 0 immediately; after release, arbitration restarts from r0.
